// File: rtl/spectrum_frame_ctrl.sv
// Spectrum frame controller.
// Captures one complete spectrum frame (sop..eop, N_POINTS valid beats) from the
// modulus stage into the write bank of a ping-pong buffer. Malformed frames are
// rejected. The banks swap only while the renderer is not drawing. The renderer
// reads bar lengths from the committed bank, with a one-cycle read latency.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   S_IDLE    | waiting for a sop beat; beats without sop are ignored
//   S_CAPTURE | storing bins 1..N-1 into the write bank
//   S_COMMIT  | full frame stored; waiting for draw_busy low before the swap
module spectrum_frame_ctrl #(
  parameter int N_POINTS = 128,
  parameter int AW       = 7,
  parameter int DW       = 16
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic [DW-1:0] mod_data,
  input  logic          mod_sop,
  input  logic          mod_eop,
  input  logic          mod_valid,
  input  logic          draw_busy,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          frame_ready,
  output logic [15:0]   frame_cnt,
  output logic [7:0]    err_cnt,
  output logic          capturing
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_COMMIT  = 2'd2
  } state_t;

  // The bin index is one bit wider than the address so that an overrun past
  // bin N-1 can be detected.
  localparam logic [AW:0] IDX_ONE  = (AW+1)'(1);
  localparam logic [AW:0] IDX_LAST = (AW+1)'(N_POINTS - 1);
  localparam logic [AW:0] IDX_END  = (AW+1)'(N_POINTS);

  state_t        state;
  logic [AW:0]   idx;
  logic [AW:0]   idx_nxt;
  logic          rd_bank;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    err_cnt_inc;

  logic [DW-1:0] bank0 [N_POINTS];
  logic [DW-1:0] bank1 [N_POINTS];

  assign idx_nxt     = idx + IDX_ONE;
  assign err_cnt_inc = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;

  // Decide whether the current beat lands in the write bank, and where it goes.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = idx[AW-1:0];
    if (mod_valid) begin
      unique case (state)
        S_IDLE: begin
          if (mod_sop && !mod_eop) begin
            wr_en   = 1'b1;
            wr_addr = '0;
          end
        end
        S_CAPTURE: begin
          if (mod_sop) begin
            wr_en   = !mod_eop;
            wr_addr = '0;
          end else if (mod_eop) begin
            wr_en = (idx == IDX_LAST);
          end else begin
            wr_en = 1'b1;
          end
        end
        default: wr_en = 1'b0;
      endcase
    end
  end

  // Write into the bank the renderer is not reading. Contents survive reset.
  always_ff @(posedge sys_clk) begin
    if (wr_en) begin
      if (rd_bank) bank0[wr_addr] <= mod_data;
      else         bank1[wr_addr] <= mod_data;
    end
  end

  // Read from the committed bank with one cycle of latency. rd_data holds when idle.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_bank ? bank1[rd_addr] : bank0[rd_addr];
    end
  end

  // Frame FSM: validate the frame, swap banks on commit, and maintain the counters.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      rd_bank     <= 1'b0;
      frame_ready <= 1'b0;
      frame_cnt   <= '0;
      err_cnt     <= '0;
      capturing   <= 1'b0;
    end else begin
      frame_ready <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (mod_valid && mod_sop) begin
            if (mod_eop) begin
              err_cnt <= err_cnt_inc;
            end else begin
              idx       <= IDX_ONE;
              state     <= S_CAPTURE;
              capturing <= 1'b1;
            end
          end
        end
        S_CAPTURE: begin
          if (mod_valid) begin
            if (mod_sop) begin
              // A new sop aborts the old frame. A sop that also carries eop is
              // malformed as well, so the FSM falls back to idle.
              err_cnt <= err_cnt_inc;
              if (mod_eop) begin
                state     <= S_IDLE;
                capturing <= 1'b0;
              end else begin
                idx <= IDX_ONE;
              end
            end else if (mod_eop) begin
              capturing <= 1'b0;
              if (idx == IDX_LAST) begin
                state <= S_COMMIT;
              end else begin
                err_cnt <= err_cnt_inc;
                state   <= S_IDLE;
              end
            end else if (idx_nxt == IDX_END) begin
              err_cnt   <= err_cnt_inc;
              state     <= S_IDLE;
              capturing <= 1'b0;
            end else begin
              idx <= idx_nxt;
            end
          end
        end
        S_COMMIT: begin
          if (mod_valid && mod_sop) err_cnt <= err_cnt_inc;
          if (!draw_busy) begin
            rd_bank     <= ~rd_bank;
            frame_ready <= 1'b1;
            frame_cnt   <= frame_cnt + 16'd1;
            state       <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          capturing <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spectrum_frame_ctrl.sv
// Bench for spectrum_frame_ctrl. The model tracks the committed frame contents
// and the expected counter values at frame level. Each test frame comes from a
// data array plus an outcome rule.
module tb_spectrum_frame_ctrl;
  localparam int N  = 128;
  localparam int AW = 7;
  localparam int DW = 16;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b0;
  logic [DW-1:0] mod_data = '0;
  logic          mod_sop = 1'b0;
  logic          mod_eop = 1'b0;
  logic          mod_valid = 1'b0;
  logic          draw_busy = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          frame_ready;
  logic [15:0]   frame_cnt;
  logic [7:0]    err_cnt;
  logic          capturing;

  spectrum_frame_ctrl #(.N_POINTS(N), .AW(AW), .DW(DW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .mod_data(mod_data), .mod_sop(mod_sop),
    .mod_eop(mod_eop), .mod_valid(mod_valid), .draw_busy(draw_busy), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .frame_ready(frame_ready),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt), .capturing(capturing)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] exp;
  } rd_vec_t;

  int          total = 0;
  int          bad = 0;
  logic [15:0] mdl_bank [N];
  logic [15:0] frame_data [N];
  int          mdl_frames = 0;
  int          mdl_err = 0;
  rd_vec_t     vt [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle_inputs();
    mod_valid = 1'b0;
    mod_sop   = 1'b0;
    mod_eop   = 1'b0;
  endtask

  task automatic err_up();
    mdl_err = (mdl_err >= 255) ? 255 : mdl_err + 1;
  endtask

  // Send frame_data[0..len-1], sop on bin 0, optional eop on the last bin, with
  // random invalid gap cycles carrying noise on the data/sop/eop lines.
  task automatic send_frame(input int len, input bit with_eop, input int gap_pct);
    for (int k = 0; k < len; k++) begin
      int g = 0;
      while (g < 8 && int'($urandom_range(99)) < gap_pct) begin
        mod_valid = 1'b0;
        mod_data  = 16'($urandom);
        mod_sop   = 1'($urandom_range(1));
        mod_eop   = 1'($urandom_range(1));
        tick();
        g++;
      end
      mod_valid = 1'b1;
      mod_data  = frame_data[k];
      mod_sop   = (k == 0);
      mod_eop   = with_eop && (k == len - 1);
      tick();
    end
    idle_inputs();
  endtask

  // A well-formed frame, held in commit for busy_cycles before the swap.
  task automatic commit_good(input int busy_cycles, input int gap_pct, input string tag);
    draw_busy = (busy_cycles > 0);
    send_frame(N, 1'b1, gap_pct);
    check({tag, "_ready_at_eop"}, frame_ready, 0);
    for (int c = 0; c < busy_cycles; c++) tick();
    if (busy_cycles > 0) check({tag, "_ready_busy"}, frame_ready, 0);
    draw_busy = 1'b0;
    tick();
    check({tag, "_ready_pulse"}, frame_ready, 1);
    mdl_frames++;
    for (int k = 0; k < N; k++) mdl_bank[k] = frame_data[k];
    check({tag, "_frame_cnt"}, frame_cnt, mdl_frames & 32'hFFFF);
    check({tag, "_err_cnt"}, err_cnt, mdl_err);
    tick();
    check({tag, "_ready_drop"}, frame_ready, 0);
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    rd_en   = 1'b0;
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < N; a++) begin
      do_read(AW'(a));
      check({tag, "_bin"}, rd_data, mdl_bank[a]);
    end
    check({tag, "_rd_valid"}, rd_valid, 1);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int len;
    int kind;
    int gap;

    vt[0] = '{addr: 7'd5,   exp: 16'd15};
    vt[1] = '{addr: 7'd0,   exp: 16'd0};
    vt[2] = '{addr: 7'd127, exp: 16'd381};
    vt[3] = '{addr: 7'd64,  exp: 16'd192};
    vt[4] = '{addr: 7'd1,   exp: 16'd3};
    vt[5] = '{addr: 7'd100, exp: 16'd300};

    // Reset state
    repeat (3) tick();
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_frame_ready", frame_ready, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_capturing", capturing, 0);
    sys_rst = 1'b1;
    tick();

    // 1: clean ramp frame, then the read table
    for (int k = 0; k < N; k++) frame_data[k] = 16'(k * 3);
    commit_good(0, 0, "t1");
    for (int i = 0; i < 6; i++) begin
      do_read(vt[i].addr);
      check("t1_table_data", rd_data, vt[i].exp);
      check("t1_table_valid", rd_valid, 1);
    end
    tick();
    check("t1_hold_valid", rd_valid, 0);
    check("t1_hold_data", rd_data, 16'd300);

    // 2: early eop on bin 99 is rejected
    for (int k = 0; k < N; k++) frame_data[k] = 16'(16'hF000 + k);
    send_frame(100, 1'b1, 0);
    err_up();
    check("t2_capturing", capturing, 0);
    tick();
    check("t2_no_ready", frame_ready, 0);
    tick();
    check("t2_no_ready2", frame_ready, 0);
    check("t2_err_cnt", err_cnt, mdl_err);
    check("t2_frame_cnt", frame_cnt, mdl_frames);
    do_read(7'd5);
    check("t2_old_data", rd_data, 16'd15);

    // 3: sop reasserted at bin 60 aborts, then a full frame of 0xAAAA
    for (int k = 0; k < N; k++) frame_data[k] = 16'(16'h1234 + k);
    send_frame(60, 1'b0, 0);
    check("t3_capturing", capturing, 1);
    err_up();
    for (int k = 0; k < N; k++) frame_data[k] = 16'hAAAA;
    commit_good(0, 0, "t3");
    read_all("t3");

    // 4: commit held by draw_busy; a sop beat during the hold is dropped and counted
    for (int k = 0; k < N; k++) frame_data[k] = 16'(k * 7 + 1);
    draw_busy = 1'b1;
    send_frame(N, 1'b1, 0);
    repeat (50) tick();
    check("t4_no_ready", frame_ready, 0);
    check("t4_frame_cnt_held", frame_cnt, mdl_frames);
    for (int k = 0; k < 10; k++) begin
      mod_valid = 1'b1;
      mod_sop   = (k == 0);
      mod_eop   = 1'b0;
      mod_data  = 16'hDEAD;
      tick();
    end
    idle_inputs();
    err_up();
    check("t4_err_cnt", err_cnt, mdl_err);
    check("t4_still_no_ready", frame_ready, 0);
    draw_busy = 1'b0;
    rd_en     = 1'b1;
    rd_addr   = 7'd5;
    tick();
    rd_en     = 1'b0;
    check("t4_ready_pulse", frame_ready, 1);
    check("t4_swap_cycle_old_bank", rd_data, mdl_bank[5]);
    mdl_frames++;
    for (int k = 0; k < N; k++) mdl_bank[k] = frame_data[k];
    check("t4_frame_cnt", frame_cnt, mdl_frames);
    do_read(7'd5);
    check("t4_new_bank", rd_data, 16'd36);
    read_all("t4");

    // 5: gap-free frame, then the same data again with 50% gaps
    for (int k = 0; k < N; k++) frame_data[k] = 16'($urandom);
    commit_good(0, 0, "t5a");
    read_all("t5a");
    commit_good(0, 50, "t5b");
    read_all("t5b");

    // Random mix of good and malformed frames
    for (int f = 0; f < 12; f++) begin
      kind = (f == 11) ? 0 : int'($urandom_range(3));
      gap  = int'($urandom_range(30));
      for (int k = 0; k < N; k++) frame_data[k] = 16'($urandom);
      case (kind)
        0: begin
          commit_good(int'($urandom_range(3)), gap, "mix_good");
          read_all("mix_good");
        end
        1: begin
          len = int'($urandom_range(127, 2));
          send_frame(len, 1'b1, gap);
          err_up();
          tick();
          check("mix_short_no_ready", frame_ready, 0);
          check("mix_short_err", err_cnt, mdl_err);
        end
        2: begin
          len = int'($urandom_range(127, 1));
          send_frame(len, 1'b0, gap);
          err_up();
          check("mix_trunc_capturing", capturing, 1);
        end
        default: begin
          send_frame(N, 1'b0, gap);
          err_up();
          check("mix_overrun_err", err_cnt, mdl_err);
          check("mix_overrun_capturing", capturing, 0);
        end
      endcase
    end

    // err_cnt saturation: many single-beat sop+eop frames
    for (int i = 0; i < 300; i++) begin
      mod_valid = 1'b1;
      mod_sop   = 1'b1;
      mod_eop   = 1'b1;
      tick();
      err_up();
    end
    idle_inputs();
    check("sat_err_cnt", err_cnt, mdl_err);
    check("sat_frame_cnt", frame_cnt, mdl_frames);

    // 6: reset at bin 40, then a clean frame commits
    for (int k = 0; k < N; k++) frame_data[k] = 16'($urandom);
    send_frame(40, 1'b0, 0);
    check("t6_capturing", capturing, 1);
    sys_rst = 1'b0;
    #2;
    mdl_frames = 0;
    mdl_err    = 0;
    check("t6_rst_rd_data", rd_data, 0);
    check("t6_rst_rd_valid", rd_valid, 0);
    check("t6_rst_frame_ready", frame_ready, 0);
    check("t6_rst_frame_cnt", frame_cnt, 0);
    check("t6_rst_err_cnt", err_cnt, 0);
    check("t6_rst_capturing", capturing, 0);
    tick();
    tick();
    sys_rst = 1'b1;
    tick();
    for (int k = 0; k < N; k++) frame_data[k] = 16'($urandom);
    commit_good(0, 0, "t6");
    read_all("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
